vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Raster timing source that drives the pixel/colour path. Divides the system clock into a pixel-rate
//   enable and runs horizontal/vertical counters. Emits pixel coordinates, vid_on, active-low h/v sync
//   and a once-per-frame game tick. Sprite generators (bird, pipe, ground, logo, back) read pixel_x/y.
//   The colour multiplexer reads vid_on. hsync/vsync go straight to the VGA connector.
// PARAMETERS
//   CLK_DIV    4    system clocks per pixel (100 MHz -> 25 MHz); must be >= 1
//   H_DISPLAY  640  visible pixels per line
//   H_FRONT    16   horizontal front porch, in pixels
//   H_SYNC     96   horizontal sync width, in pixels
//   H_BACK     48   horizontal back porch, in pixels (H_TOTAL = 800)
//   V_DISPLAY  480  visible lines per frame
//   V_FRONT    10   vertical front porch, in lines
//   V_SYNC     2    vertical sync width, in lines
//   V_BACK     33   vertical back porch, in lines (V_TOTAL = 525)
// PORTS
//   clk         in   1   system clock, 100 MHz
//   reset_n     in   1   synchronous reset, active-low
//   p_tick      out  1   pixel enable; high 1 clk in every CLK_DIV clks
//   pixel_x     out  10  horizontal count, 0..H_TOTAL-1
//   pixel_y     out  10  vertical count, 0..V_TOTAL-1
//   vid_on      out  1   high when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
//   hsync       out  1   horizontal sync, active-low
//   vsync       out  1   vertical sync, active-low
//   frame_tick  out  1   1-clk pulse at entry to vertical blanking
// BEHAVIOUR
//   Reset: one clk, reset_n=0 sampled at posedge, all state synchronous.
//   - Clears div_cnt, pixel_x and pixel_y to 0.
//   - Forces p_tick=0, vid_on=0, frame_tick=0, hsync=1, vsync=1.
//   - Reset mid-line/mid-frame: abandons the raster and restarts at (0,0) with no partial sync pulse.
//   Divider: div_cnt counts 0..CLK_DIV-1 and wraps to 0.
//   - p_tick is registered; it is high in the clk after div_cnt==CLK_DIV-1.
//   - The first p_tick after reset release is at clk CLK_DIV. CLK_DIV=1 gives p_tick high every clk.
//   Counters advance only on cycles where div_cnt==CLK_DIV-1:
//   - pixel_x: +1, or wraps to 0 when pixel_x==H_TOTAL-1.
//   - pixel_y: +1 only when pixel_x wraps. It wraps to 0 when pixel_y==V_TOTAL-1 and pixel_x wraps.
//   Sync/blank decode: registered from the NEXT counter values, so outputs align with pixel_x/y every clk.
//   - hsync=0 iff H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC, i.e. x in 656..751 by default.
//   - vsync=0 iff V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC, i.e. y in 490..491 by default.
//   - vid_on as defined in PORTS. It is 1 in the first clk after reset release, since (0,0) is visible.
//   frame_tick: registered, high exactly 1 clk in the same clk that pixel_y changes to V_DISPLAY.
//   - Never asserted during reset.
//   - Game logic samples positions on this pulse, so updates happen during blanking only.
//   Widths: counters are 10 bit. H_TOTAL and V_TOTAL must be <= 1024; larger values are a config error.
//   No output holds X after reset. All outputs are glitch-free, driven directly from flops.
// TESTING
//   1 Reset: hold reset_n=0 for 5 clks.
//     -> pixel_x=0, pixel_y=0, hsync=1, vsync=1, p_tick=0, frame_tick=0 and vid_on=0 on every clk.
//   2 Pixel rate: release reset.
//     -> p_tick first high at clk 4 (default CLK_DIV), then exactly every 4 clks.
//     -> pixel_x steps 0,1,2 at 4-clk spacing.
//   3 Line timing, one full line:
//     -> hsync low for 384 clks starting when pixel_x becomes 656.
//     -> hsync period 3200 clks; vid_on high for 2560 clks per visible line.
//     -> pixel_y increments when pixel_x wraps 799->0.
//   4 Frame timing, run 2 frames:
//     -> vsync low while pixel_y is 490..491, 6400 clks.
//     -> frame_tick exactly once per 1,680,000 clks, coincident with pixel_y becoming 480.
//     -> 307,200 p_ticks with vid_on=1 per frame.
//   5 Reset mid-operation: pulse reset_n=0 for 1 clk at pixel_x=700, pixel_y=491, where hsync=0 and vsync=0.
//     -> next clk hsync=1, vsync=1 and counters at (0,0).
//     -> timing then matches scenario 2 exactly.
//   6 CLK_DIV=1 build: p_tick constantly high after reset; hsync period 800 clks; hsync low width 96 clks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing source for the pixel/colour path. The system clock is
//   divided into a pixel-rate enable (p_tick). Horizontal and vertical
//   counters advance on that enable. Sync, blank and frame-tick outputs are
//   decoded from the counters.
//
// Ports
//   clk         in   1   system clock
//   reset_n     in   1   synchronous reset, active-low
//   p_tick      out  1   pixel enable, high 1 clk in every CLK_DIV clks
//   pixel_x     out  10  horizontal count, 0..H_TOTAL-1
//   pixel_y     out  10  vertical count, 0..V_TOTAL-1
//   vid_on      out  1   high inside the visible area
//   hsync       out  1   horizontal sync, active-low
//   vsync       out  1   vertical sync, active-low
//   frame_tick  out  1   1-clk pulse when pixel_y enters vertical blanking
//
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       vid_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Decode bounds are kept 11 bits wide so that a sync pulse ending exactly
    // at 1024 (zero back porch, full 10-bit counter) still compares correctly.
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
    localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Configuration guards, evaluated at elaboration only.
    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be >= 1");
        end
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [9:0]       x_reg, x_next;
    logic [9:0]       y_reg, y_next;
    logic             p_tick_reg, p_tick_next;
    logic             vid_on_reg, vid_on_next;
    logic             hsync_reg, hsync_next;
    logic             vsync_reg, vsync_next;
    logic             frame_tick_reg, frame_tick_next;
    logic             advance;
    logic             x_wrap;
    logic [10:0]      x_ext, y_ext;

    // Counters step on the last divider phase, which is the same edge that
    // raises p_tick, so p_tick and the new pixel coordinates appear together.
    assign advance = (div_cnt_reg == DIV_LAST);
    assign x_wrap  = ({1'b0, x_reg} == H_LAST);

    always_comb begin
        div_cnt_next    = advance ? '0 : div_cnt_reg + 1'b1;
        x_next          = x_reg;
        y_next          = y_reg;
        frame_tick_next = 1'b0;
        if (advance) begin
            if (x_wrap) begin
                x_next = '0;
                y_next = ({1'b0, y_reg} == V_LAST) ? 10'd0 : y_reg + 10'd1;
                // Pulse only on the edge where y moves onto the first blank line.
                frame_tick_next = ({1'b0, y_next} == V_VIS);
            end else begin
                x_next = x_reg + 10'd1;
            end
        end
        p_tick_next = advance;

        // Decode from the next counter values so that the registered sync and
        // blank outputs line up with the registered coordinates.
        x_ext       = {1'b0, x_next};
        y_ext       = {1'b0, y_next};
        vid_on_next = (x_ext < H_VIS) && (y_ext < V_VIS);
        hsync_next  = !((x_ext >= HS_START) && (x_ext < HS_END));
        vsync_next  = !((y_ext >= VS_START) && (y_ext < VS_END));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_reg    <= '0;
            x_reg          <= '0;
            y_reg          <= '0;
            p_tick_reg     <= 1'b0;
            vid_on_reg     <= 1'b0;
            hsync_reg      <= 1'b1;
            vsync_reg      <= 1'b1;
            frame_tick_reg <= 1'b0;
        end else begin
            div_cnt_reg    <= div_cnt_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            p_tick_reg     <= p_tick_next;
            vid_on_reg     <= vid_on_next;
            hsync_reg      <= hsync_next;
            vsync_reg      <= vsync_next;
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign p_tick     = p_tick_reg;
    assign pixel_x    = x_reg;
    assign pixel_y    = y_reg;
    assign vid_on     = vid_on_reg;
    assign hsync      = hsync_reg;
    assign vsync      = vsync_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances with a shrunken raster (32 x 19) so that whole frames fit
//   in a short run: one with CLK_DIV=3, one with CLK_DIV=1. Both share one
//   reset. Every clk, all outputs of both instances are compared against a
//   reference that derives the expected raster position from the number of
//   clocks elapsed since reset release, using plain division and modulo.
//   The stimulus is a sequence of run segments with random lengths, each
//   ended by a reset pulse. One segment stops inside the h/v sync region to
//   exercise reset abandoning the raster. One line is printed per segment.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int DIV_A = 3;
    localparam int DIV_B = 1;
    localparam int HD = 20, HF = 3, HS = 4, HB = 5;
    localparam int VD = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HD + HF + HS + HB;   // 32
    localparam int VT = VD + VF + VS + VB;   // 19

    logic       clk;
    logic       reset_n;
    logic       p_tick_a, vid_on_a, hsync_a, vsync_a, frame_tick_a;
    logic [9:0] pixel_x_a, pixel_y_a;
    logic       p_tick_b, vid_on_b, hsync_b, vsync_b, frame_tick_b;
    logic [9:0] pixel_x_b, pixel_y_b;

    int checks = 0;
    int errors = 0;

    vga_timing_gen #(
        .CLK_DIV(DIV_A), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .p_tick(p_tick_a),
        .pixel_x(pixel_x_a), .pixel_y(pixel_y_a), .vid_on(vid_on_a),
        .hsync(hsync_a), .vsync(vsync_a), .frame_tick(frame_tick_a)
    );

    vga_timing_gen #(
        .CLK_DIV(DIV_B), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .p_tick(p_tick_b),
        .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .vid_on(vid_on_b),
        .hsync(hsync_b), .vsync(vsync_b), .frame_tick(frame_tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    typedef struct packed {
        logic       pt;
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
        logic       vs;
        logic       ft;
    } exp_t;

    // Reference: n = clock edges since the reset edge, d = clocks per pixel.
    // A pixel completes every d clocks; its index gives x and y directly.
    function automatic exp_t model(input int n, input int d, input bit rst);
        exp_t e;
        int p, x, y;
        if (rst) begin
            e = '{pt: 1'b0, x: 10'd0, y: 10'd0, von: 1'b0, hs: 1'b1, vs: 1'b1, ft: 1'b0};
        end else begin
            p    = n / d;
            x    = p % HT;
            y    = (p / HT) % VT;
            e.pt = (n % d) == 0;
            e.x  = 10'(x);
            e.y  = 10'(y);
            e.von = (x < HD) && (y < VD);
            e.hs  = !((x >= HD + HF) && (x < HD + HF + HS));
            e.vs  = !((y >= VD + VF) && (y < VD + VF + VS));
            e.ft  = e.pt && (x == 0) && (y == VD);
        end
        return e;
    endfunction

    // Bookkeeping of what the DUTs sampled at the last posedge.
    bit started  = 1'b0;
    bit in_reset = 1'b1;
    int n_edges  = 0;

    always @(posedge clk) begin
        started  <= 1'b1;
        in_reset <= !reset_n;
        n_edges  <= reset_n ? n_edges + 1 : 0;
    end

    always @(negedge clk) begin
        exp_t ea, eb;
        if (started) begin
            ea = model(n_edges, DIV_A, in_reset);
            eb = model(n_edges, DIV_B, in_reset);
            check_val("a_p_tick",     32'(p_tick_a),     32'(ea.pt));
            check_val("a_pixel_x",    32'(pixel_x_a),    32'(ea.x));
            check_val("a_pixel_y",    32'(pixel_y_a),    32'(ea.y));
            check_val("a_vid_on",     32'(vid_on_a),     32'(ea.von));
            check_val("a_hsync",      32'(hsync_a),      32'(ea.hs));
            check_val("a_vsync",      32'(vsync_a),      32'(ea.vs));
            check_val("a_frame_tick", 32'(frame_tick_a), 32'(ea.ft));
            check_val("b_p_tick",     32'(p_tick_b),     32'(eb.pt));
            check_val("b_pixel_x",    32'(pixel_x_b),    32'(eb.x));
            check_val("b_pixel_y",    32'(pixel_y_b),    32'(eb.y));
            check_val("b_vid_on",     32'(vid_on_b),     32'(eb.von));
            check_val("b_hsync",      32'(hsync_b),      32'(eb.hs));
            check_val("b_vsync",      32'(vsync_b),      32'(eb.vs));
            check_val("b_frame_tick", 32'(frame_tick_b), 32'(eb.ft));
        end
    end

    // Segment: run `len` clks out of reset, then hold reset for `rst_len` clks.
    task automatic run_segment(input int idx, input int len, input int rst_len);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (len) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (rst_len) @(posedge clk);
        $display("segment %0d: ran %0d clks, reset %0d clks, checks so far %0d",
                 idx, len, rst_len, checks);
    endtask

    localparam int FRAME_A = HT * VT * DIV_A;
    // Pixel (x=24, y=15) lies inside both hsync and vsync on instance A.
    localparam int SYNC_HIT = ((VD + VF + 1) * HT + (HD + HF + 1)) * DIV_A;

    initial begin
        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        $display("segment 0: initial reset 5 clks, checks so far %0d", checks);
        run_segment(1, 2 * FRAME_A + int'($urandom_range(0, 40)), 1);
        run_segment(2, SYNC_HIT, 1);
        run_segment(3, 2 * DIV_A + 1, int'($urandom_range(1, 3)));
        for (int s = 4; s < 10; s++) begin
            run_segment(s, int'($urandom_range(20, 1500)), int'($urandom_range(1, 4)));
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (FRAME_A + 10) @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
